sda_rx: RTL and testbench
=========================

// Module: sda_rx
// PURPOSE
//  Receive-side front end of the I2C slave; the input counterpart of the SDA output selector.
//  Synchronises raw SCL/SDA and detects START/STOP. Shifts in address and write-data bytes MSB first.
//  Flags address match, R/W and ACK-slot timing, and samples the master ACK/NACK after each slave-transmitted byte.
//  Outputs feed the slave controller FSM, which drives sda_mode on the output selector.
// PARAMETERS
//  SLAVE_ADDR  7'b1111000  7-bit bus address this slave answers to
// PORTS
//  clk            in   1  system clock; all logic on rising edge
//  rst            in   1  asynchronous reset, active-high
//  scl_in         in   1  raw bus SCL (asynchronous to clk)
//  sda_in         in   1  raw bus SDA (asynchronous to clk)
//  start_found    out  1  1-cycle pulse: START or repeated START detected
//  stop_found     out  1  1-cycle pulse: STOP detected
//  rx_data        out  8  last completed received byte; held until the next byte completes
//  byte_received  out  1  1-cycle pulse: rx_data just updated
//  addr_match     out  1  1-cycle pulse: address byte equals SLAVE_ADDR
//  rw_mode        out  1  R/W bit of the last matched address (1 = master reads)
//  ack_phase      out  1  level: high for the whole 9th (ACK) SCL bit slot
//  ack_sampled    out  1  1-cycle pulse: master ACK/NACK sampled in read mode
//  ack_value      out  1  1 = ACK (SDA low), 0 = NACK; valid with ack_sampled, held after
// BEHAVIOUR
//  Reset:
//   - All sync flops reset to 1 (idle bus).
//   - rx_data = 0, rw_mode = 0, ack_value = 0; all pulse outputs and ack_phase = 0; FSM = IDLE.
//   - Reset asserted mid-transfer aborts the transfer. After release the block waits for a new START.
//  Synchroniser and edge detection:
//   - scl_in and sda_in each pass through 2 sync flops plus 1 previous-value flop.
//   - scl_rise = scl_s & ~scl_p; scl_fall = ~scl_s & scl_p.
//   - Total input-to-event latency is 3 clk.
//   - START = sda_s falls while scl_s & scl_p are high. STOP = sda_s rises under the same condition.
//   - A START/STOP never also counts as a data bit.
//  Bit counter and shift register:
//   - bit_cnt is 4 bits, cleared on START and on entry to each byte.
//   - On each scl_rise in a receive state: shift <= {shift[6:0], sda_s}; bit_cnt++.
//   - On the 8th rise: rx_data <= shifted byte, and byte_received pulses on the next clk.
//  FSM states:
//   IDLE:
//    - Ignores the bus; START -> ADDR.
//   ADDR:
//    - After 8 bits, if byte[7:1] == SLAVE_ADDR: addr_match pulse, rw_mode <= byte[0], -> ACK_SLOT.
//    - Otherwise -> IDLE (no ack_phase).
//   ACK_SLOT:
//    - ack_phase is high from the scl_fall after the 8th bit to the scl_fall after the 9th bit.
//    - Then -> DATA_RX if rw_mode = 0, or -> TX_WAIT if rw_mode = 1.
//   DATA_RX:
//    - Receives 8 bits, then -> ACK_SLOT (slave ACKs every write byte).
//   TX_WAIT:
//    - Counts 8 scl_rise edges of the slave-driven byte without updating rx_data, then -> MACK.
//   MACK:
//    - ack_phase is high across the slot.
//    - On the 9th scl_rise: ack_sampled pulse, ack_value <= ~sda_s.
//    - On the next scl_fall: ACK -> TX_WAIT, NACK -> IDLE.
//  Override events:
//   - START in any state -> ADDR: bit_cnt cleared, ack_phase dropped the same clk.
//   - STOP in any state -> IDLE; rx_data and rw_mode retained.
//   - START and scl_rise can never coincide, since START requires SCL high on both samples.
//  Addressing:
//   - Address byte 0x00 (general call) is not matched unless SLAVE_ADDR == 0.
//   - No clock stretching; SCL is input only.
// TESTING
//  1. Write: START, addr 0xF0, ACK slot, data 0xA5, STOP.
//     -> start_found, addr_match with rw_mode = 0, byte_received with rx_data = 0xA5;
//        ack_phase high on both 9th slots; stop_found; FSM back to IDLE.
//  2. Address 0x42 -> byte_received with rx_data = 0x42, no addr_match, no ack_phase.
//     A following data byte 0x11 is ignored (no byte_received).
//  3. Read: addr 0xF1, 2 slave bytes, master ACK then NACK.
//     -> rw_mode = 1, ack_sampled twice with ack_value = 1 then 0; FSM back to IDLE;
//        rx_data stays 0xF1.
//  4. Repeated START after bit 4 of a data byte -> start_found; next 8 bits parse as an address;
//     the partial byte is discarded, with no byte_received.
//  5. rst pulse asserted asynchronously mid-byte (between clk edges).
//     -> all outputs 0 and FSM in IDLE immediately; subsequent SCL pulses without START
//        give no byte_received.
//  6. SDA glitches while SCL low, and two back-to-back transactions with a 1-clk STOP-to-START gap
//     -> no false START/STOP; both transactions decode correctly.

Source files
------------

// File: rtl/sda_rx.sv
// I2C slave receive front end: synchronises SCL/SDA, detects START/STOP, shifts in
// address/write bytes MSB first, and tracks ACK slots and the master ACK in read mode.
module sda_rx #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       start_found,
   output logic       stop_found,
   output logic [7:0] rx_data,
   output logic       byte_received,
   output logic       addr_match,
   output logic       rw_mode,
   output logic       ack_phase,
   output logic       ack_sampled,
   output logic       ack_value
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_SLOT,
      DATA_RX,
      TX_WAIT,
      MACK
   } state_t;

   state_t state, state_next;

   logic scl_m, scl_s, scl_p;
   logic sda_m, sda_s, sda_p;

   logic [3:0] bit_cnt;
   logic [6:0] shift;
   logic [7:0] byte_next;

   logic scl_rise, scl_fall, bus_start, bus_stop, last_bit;
   logic cnt_clr, cnt_inc, shift_en, load_rx, match, phase_set, phase_clr, sample_ack;

   // Sync flops reset to 1 so a reset on an idle bus produces no spurious edges.
   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_m <= 1'b1;
         scl_s <= 1'b1;
         scl_p <= 1'b1;
         sda_m <= 1'b1;
         sda_s <= 1'b1;
         sda_p <= 1'b1;
      end else begin
         scl_m <= scl_in;
         scl_s <= scl_m;
         scl_p <= scl_s;
         sda_m <= sda_in;
         sda_s <= sda_m;
         sda_p <= sda_s;
      end
   end

   assign scl_rise  = scl_s & ~scl_p;
   assign scl_fall  = ~scl_s & scl_p;
   assign bus_start = scl_s & scl_p & ~sda_s & sda_p;
   assign bus_stop  = scl_s & scl_p & sda_s & ~sda_p;
   assign byte_next = {shift, sda_s};
   assign last_bit  = (bit_cnt == 4'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every signal written here gets a default first, so no latches are inferred.
   always_comb begin
      state_next = state;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      shift_en   = 1'b0;
      load_rx    = 1'b0;
      match      = 1'b0;
      phase_set  = 1'b0;
      phase_clr  = 1'b0;
      sample_ack = 1'b0;

      if (bus_start) begin
         state_next = ADDR;
         cnt_clr    = 1'b1;
         phase_clr  = 1'b1;
      end else if (bus_stop) begin
         state_next = IDLE;
         phase_clr  = 1'b1;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise) begin
                  shift_en = 1'b1;
                  cnt_inc  = 1'b1;
                  if (last_bit) begin
                     load_rx = 1'b1;
                     if (byte_next[7:1] == SLAVE_ADDR) begin
                        match      = 1'b1;
                        state_next = ACK_SLOT;
                     end else begin
                        state_next = IDLE;
                     end
                  end
               end
            end
            DATA_RX: begin
               if (scl_rise) begin
                  shift_en = 1'b1;
                  cnt_inc  = 1'b1;
                  if (last_bit) begin
                     load_rx    = 1'b1;
                     state_next = ACK_SLOT;
                  end
               end
            end
            // ack_phase doubles as the slot sub-state: first fall opens it, second closes it.
            ACK_SLOT: begin
               if (scl_fall) begin
                  if (!ack_phase) begin
                     phase_set = 1'b1;
                  end else begin
                     phase_clr  = 1'b1;
                     cnt_clr    = 1'b1;
                     state_next = rw_mode ? TX_WAIT : DATA_RX;
                  end
               end
            end
            TX_WAIT: begin
               if (scl_rise) begin
                  cnt_inc = 1'b1;
                  if (last_bit) state_next = MACK;
               end
            end
            MACK: begin
               if (scl_rise && ack_phase) sample_ack = 1'b1;
               if (scl_fall) begin
                  if (!ack_phase) begin
                     phase_set = 1'b1;
                  end else begin
                     phase_clr  = 1'b1;
                     cnt_clr    = 1'b1;
                     state_next = ack_value ? TX_WAIT : IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt       <= 4'd0;
         shift         <= 7'd0;
         rx_data       <= 8'd0;
         rw_mode       <= 1'b0;
         ack_value     <= 1'b0;
         ack_phase     <= 1'b0;
         start_found   <= 1'b0;
         stop_found    <= 1'b0;
         byte_received <= 1'b0;
         addr_match    <= 1'b0;
         ack_sampled   <= 1'b0;
      end else begin
         start_found   <= bus_start;
         stop_found    <= bus_stop;
         byte_received <= load_rx;
         addr_match    <= match;
         ack_sampled   <= sample_ack;

         if (cnt_clr)      bit_cnt <= 4'd0;
         else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;

         if (shift_en)   shift     <= byte_next[6:0];
         if (load_rx)    rx_data   <= byte_next;
         if (match)      rw_mode   <= byte_next[0];
         if (sample_ack) ack_value <= ~sda_s;

         if (phase_clr)      ack_phase <= 1'b0;
         else if (phase_set) ack_phase <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sda_rx.sv
// Directed bench for sda_rx: drives I2C bus waveforms and checks the decoded
// events against hand-computed expectations.
module tb_sda_rx;

   localparam int Q = 4;   // clocks from SCL edge to SDA change / next SCL edge
   localparam int H = 8;   // clocks SCL held high per bit

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_in, sda_in;
   logic       start_found, stop_found, byte_received, addr_match;
   logic       rw_mode, ack_phase, ack_sampled, ack_value;
   logic [7:0] rx_data;

   int n_checks = 0;
   int n_fail   = 0;

   int n_start = 0, n_stop = 0, n_phase = 0;
   logic phase_q = 1'b0;
   logic [7:0] rx_hist[$];
   logic       rw_hist[$];
   logic       ack_hist[$];

   int s_start, s_stop, s_phase, s_byte, s_match, s_ack;
   logic ph, ph_dummy;

   sda_rx dut (
      .clk           (clk),
      .rst           (rst),
      .scl_in        (scl_in),
      .sda_in        (sda_in),
      .start_found   (start_found),
      .stop_found    (stop_found),
      .rx_data       (rx_data),
      .byte_received (byte_received),
      .addr_match    (addr_match),
      .rw_mode       (rw_mode),
      .ack_phase     (ack_phase),
      .ack_sampled   (ack_sampled),
      .ack_value     (ack_value)
   );

   always #5 clk = ~clk;

   // Event monitor: counts pulse cycles and records values presented with each pulse.
   always @(negedge clk) begin
      if (start_found)   n_start <= n_start + 1;
      if (stop_found)    n_stop  <= n_stop + 1;
      if (byte_received) rx_hist.push_back(rx_data);
      if (addr_match)    rw_hist.push_back(rw_mode);
      if (ack_sampled)   ack_hist.push_back(ack_value);
      if (ack_phase && !phase_q) n_phase <= n_phase + 1;
      phase_q <= ack_phase;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      wait_clk(2);
      s_start = n_start;
      s_stop  = n_stop;
      s_phase = n_phase;
      s_byte  = rx_hist.size();
      s_match = rw_hist.size();
      s_ack   = ack_hist.size();
   endtask

   task automatic bus_start();
      sda_in = 1'b1; wait_clk(Q);
      scl_in = 1'b1; wait_clk(Q);
      sda_in = 1'b0; wait_clk(Q);
      scl_in = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      sda_in = 1'b0; wait_clk(Q);
      scl_in = 1'b1; wait_clk(Q);
      sda_in = 1'b1; wait_clk(Q);
   endtask

   // STOP followed by START with SDA high for a single clock.
   task automatic stop_start();
      sda_in = 1'b0; wait_clk(Q);
      scl_in = 1'b1; wait_clk(Q);
      sda_in = 1'b1; wait_clk(1);
      sda_in = 1'b0; wait_clk(Q);
      scl_in = 1'b0; wait_clk(Q);
   endtask

   task automatic send_bit(input logic b, input logic glitch, output logic phase_hi);
      if (glitch) begin
         sda_in = ~b; wait_clk(1);
         sda_in = b;  wait_clk(1);
         sda_in = ~b; wait_clk(1);
      end
      sda_in = b;    wait_clk(Q);
      scl_in = 1'b1; wait_clk(H / 2);
      phase_hi = ack_phase;
      wait_clk(H / 2);
      scl_in = 1'b0; wait_clk(Q);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic glitch, output logic last_phase);
      for (int i = 7; i >= 0; i--) send_bit(d[i], glitch, last_phase);
   endtask

   task automatic check_deltas(input string t, input int d_start, input int d_stop,
                               input int d_byte, input int d_match, input int d_ack,
                               input int d_phase);
      check({t, "_start_cnt"}, n_start - s_start, d_start);
      check({t, "_stop_cnt"},  n_stop - s_stop, d_stop);
      check({t, "_byte_cnt"},  rx_hist.size() - s_byte, d_byte);
      check({t, "_match_cnt"}, rw_hist.size() - s_match, d_match);
      check({t, "_acks_cnt"},  ack_hist.size() - s_ack, d_ack);
      check({t, "_phase_cnt"}, n_phase - s_phase, d_phase);
   endtask

   initial begin
      rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
      wait_clk(3);
      check("rst_rx_data", rx_data, 0);
      check("rst_rw_mode", rw_mode, 0);
      check("rst_ack_value", ack_value, 0);
      check("rst_ack_phase", ack_phase, 0);
      check("rst_pulses", {start_found, stop_found, byte_received, addr_match, ack_sampled}, 0);
      rst = 1'b0;
      wait_clk(4);

      // 1: write address 0xF0, data 0xA5, STOP, then bits on an idle bus.
      snap();
      bus_start();
      send_byte(8'hF0, 1'b0, ph);
      check("t1_phase_bit8", ph, 0);
      send_bit(1'b0, 1'b0, ph);
      check("t1_phase_addr_slot", ph, 1);
      send_byte(8'hA5, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph);
      check("t1_phase_data_slot", ph, 1);
      check("t1_phase_after_slot", ack_phase, 0);
      bus_stop();
      snap();
      check_deltas("t1", 0, 0, 0, 0, 0, 0);
      s_start = n_start - 1; s_stop = n_stop - 1; s_phase = n_phase - 2;
      s_byte = rx_hist.size() - 2; s_match = rw_hist.size() - 1;
      check_deltas("t1", 1, 1, 2, 1, 0, 2);
      check("t1_rx_addr", rx_hist[s_byte], 8'hF0);
      check("t1_rx_data", rx_hist[s_byte + 1], 8'hA5);
      check("t1_rw_mode", rw_hist[s_match], 0);
      check("t1_rx_held", rx_data, 8'hA5);
      snap();
      send_byte(8'hF0, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph);
      check_deltas("t1_idle", 0, 0, 0, 0, 0, 0);

      // 2: unmatched address 0x42, following byte 0x11 ignored.
      sda_in = 1'b1; scl_in = 1'b1; wait_clk(Q);
      snap();
      bus_start();
      send_byte(8'h42, 1'b0, ph_dummy);
      send_bit(1'b1, 1'b0, ph);
      check("t2_no_phase", ph, 0);
      send_byte(8'h11, 1'b0, ph_dummy);
      send_bit(1'b1, 1'b0, ph_dummy);
      bus_stop();
      wait_clk(Q);
      check_deltas("t2", 1, 1, 1, 0, 0, 0);
      check("t2_rx", rx_hist[s_byte], 8'h42);

      // 3: read, two slave bytes, master ACK then NACK, then bits on an idle bus.
      snap();
      bus_start();
      send_byte(8'hF1, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph);
      send_byte(8'h3C, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph);
      check("t3_phase_mack1", ph, 1);
      send_byte(8'h81, 1'b0, ph_dummy);
      send_bit(1'b1, 1'b0, ph);
      check("t3_phase_mack2", ph, 1);
      send_byte(8'h5A, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph_dummy);
      bus_stop();
      wait_clk(Q);
      check_deltas("t3", 1, 1, 1, 1, 2, 3);
      check("t3_rw_mode", rw_hist[s_match], 1);
      check("t3_ack_first", ack_hist[s_ack], 1);
      check("t3_ack_second", ack_hist[s_ack + 1], 0);
      check("t3_ack_value_held", ack_value, 0);
      check("t3_rx_held", rx_data, 8'hF1);

      // 4: repeated START after 4 data bits; next 8 bits are an address.
      snap();
      bus_start();
      send_byte(8'hF0, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph_dummy);
      for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1, 1'b0, ph_dummy);
      bus_start();
      send_byte(8'hF1, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph_dummy);
      bus_stop();
      wait_clk(Q);
      check_deltas("t4", 2, 1, 2, 2, 0, 2);
      check("t4_rx_first", rx_hist[s_byte], 8'hF0);
      check("t4_rx_readdr", rx_hist[s_byte + 1], 8'hF1);
      check("t4_rw_mode", rw_hist[s_match + 1], 1);

      // 5: asynchronous reset mid-byte of a read transfer.
      bus_start();
      send_byte(8'hF1, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph_dummy);
      send_byte(8'h3C, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph_dummy);
      send_bit(1'b1, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph_dummy);
      send_bit(1'b1, 1'b0, ph_dummy);
      check("t5_pre_rw", rw_mode, 1);
      check("t5_pre_ackv", ack_value, 1);
      wait_clk(1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_rx_data", rx_data, 0);
      check("t5_rst_rw_mode", rw_mode, 0);
      check("t5_rst_ack_value", ack_value, 0);
      check("t5_rst_outputs", {ack_phase, start_found, stop_found, byte_received,
                               addr_match, ack_sampled}, 0);
      wait_clk(2);
      rst = 1'b0;
      wait_clk(Q);
      snap();
      send_byte(8'hF0, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph_dummy);
      send_byte(8'hF0, 1'b0, ph_dummy);
      check_deltas("t5_after", 0, 0, 0, 0, 0, 0);

      // 6: SDA glitches while SCL low; STOP-to-START gap of one clock.
      snap();
      bus_start();
      send_byte(8'hF0, 1'b1, ph_dummy);
      send_bit(1'b0, 1'b1, ph_dummy);
      send_byte(8'h5A, 1'b1, ph_dummy);
      send_bit(1'b0, 1'b1, ph_dummy);
      stop_start();
      send_byte(8'hF0, 1'b0, ph_dummy);
      send_bit(1'b0, 1'b0, ph_dummy);
      send_byte(8'hC3, 1'b1, ph_dummy);
      send_bit(1'b0, 1'b0, ph_dummy);
      bus_stop();
      wait_clk(Q);
      check_deltas("t6", 2, 2, 4, 2, 0, 4);
      check("t6_rx0", rx_hist[s_byte], 8'hF0);
      check("t6_rx1", rx_hist[s_byte + 1], 8'h5A);
      check("t6_rx2", rx_hist[s_byte + 2], 8'hF0);
      check("t6_rx3", rx_hist[s_byte + 3], 8'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
